// File: rtl/mix_columns_serial.sv
// Byte-serial AES MixColumns / InvMixColumns stage: gathers one column of four
// bytes, transforms it on the row3 edge, then streams the four results out.
module mix_columns_serial (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rst_synch,
    input  logic [7:0] din,
    input  logic       din_valid,
    input  logic       inverse,
    input  logic       bypass,
    output logic [7:0] dout,
    output logic       dout_valid,
    output logic       dout_last
);

    // Handshake: valid-only streaming. A byte is transferred on every rising
    // edge where din_valid is high (no ready, no stall); dout is meaningful on
    // every cycle where dout_valid is high and must be consumed that cycle.

    logic [1:0]      row_cnt;
    logic [1:0]      col_cnt;
    logic [7:0]      a0, a1, a2;
    logic [3:0][7:0] sr;
    logic [2:0]      out_cnt;
    logic            last_col;

    logic            load;
    logic [3:0][7:0] col_in;
    logic [3:0][7:0] col_fwd;
    logic [3:0][7:0] col_inv;
    logic [3:0][7:0] col_res;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        xtime = {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] mul3(input logic [7:0] b);
        mul3 = xtime(b) ^ b;
    endfunction

    function automatic logic [7:0] mul9(input logic [7:0] b);
        mul9 = xtime(xtime(xtime(b))) ^ b;
    endfunction

    function automatic logic [7:0] mulb(input logic [7:0] b);
        mulb = xtime(xtime(xtime(b))) ^ xtime(b) ^ b;
    endfunction

    function automatic logic [7:0] muld(input logic [7:0] b);
        muld = xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ b;
    endfunction

    function automatic logic [7:0] mule(input logic [7:0] b);
        mule = xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ xtime(b);
    endfunction

    assign load = din_valid && (row_cnt == 2'd3);

    // Row3 arrives on din, so the column is complete combinationally at the load edge.
    always_comb begin
        col_in  = {din, a2, a1, a0};
        col_fwd = '0;
        col_inv = '0;
        col_res = '0;
        for (int i = 0; i < 4; i++) begin
            col_fwd[i] = xtime(col_in[i]) ^ mul3(col_in[2'(i + 1)]) ^
                         col_in[2'(i + 2)] ^ col_in[2'(i + 3)];
            col_inv[i] = mule(col_in[i]) ^ mulb(col_in[2'(i + 1)]) ^
                         muld(col_in[2'(i + 2)]) ^ mul9(col_in[2'(i + 3)]);
        end
        if (bypass)
            col_res = col_in;
        else if (inverse)
            col_res = col_inv;
        else
            col_res = col_fwd;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_cnt  <= 2'd0;
            col_cnt  <= 2'd0;
            a0       <= 8'h00;
            a1       <= 8'h00;
            a2       <= 8'h00;
            sr       <= '0;
            out_cnt  <= 3'd0;
            last_col <= 1'b0;
        end else if (rst_synch) begin
            row_cnt  <= 2'd0;
            col_cnt  <= 2'd0;
            a0       <= 8'h00;
            a1       <= 8'h00;
            a2       <= 8'h00;
            sr       <= '0;
            out_cnt  <= 3'd0;
            last_col <= 1'b0;
        end else begin
            if (din_valid) begin
                row_cnt <= row_cnt + 2'd1;
                case (row_cnt)
                    2'd0:    a0 <= din;
                    2'd1:    a1 <= din;
                    2'd2:    a2 <= din;
                    default: col_cnt <= col_cnt + 2'd1;
                endcase
            end
            // A load can only meet a draining count of 1, so it simply wins.
            if (load) begin
                sr       <= col_res;
                out_cnt  <= 3'd4;
                last_col <= (col_cnt == 2'd3);
            end else if (out_cnt != 3'd0) begin
                sr      <= {8'h00, sr[3:1]};
                out_cnt <= out_cnt - 3'd1;
            end
        end
    end

    assign dout       = sr[0];
    assign dout_valid = (out_cnt != 3'd0);
    assign dout_last  = dout_valid && last_col && (out_cnt == 3'd1);

endmodule

// File: tb/tb_mix_columns_serial.sv
// Bench for mix_columns_serial: GF(2^8) matrix model with per-cycle timed
// expectations, plus literal vectors pinning the model.
module tb_mix_columns_serial;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rst_synch = 1'b0;
    logic [7:0] din = 8'h00;
    logic       din_valid = 1'b0;
    logic       inverse = 1'b0;
    logic       bypass = 1'b0;
    logic [7:0] dout;
    logic       dout_valid;
    logic       dout_last;

    int n_checks = 0;
    int n_pass = 0;
    int cyc = 0;

    // expected entries: {last, byte} and the cycle they must appear in
    logic [8:0] exp_q[$];
    int         exp_cyc_q[$];

    logic [31:0] part;
    int          part_n = 0;
    int          blk_col = 0;

    mix_columns_serial dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rst_synch  (rst_synch),
        .din        (din),
        .din_valid  (din_valid),
        .inverse    (inverse),
        .bypass     (bypass),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_last  (dout_last)
    );

    // clock / reset block
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: run did not finish, got timeout, need completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] y);
        logic [7:0] p = 8'h00;
        logic [7:0] a = x;
        logic [7:0] b = y;
        for (int k = 0; k < 8; k++) begin
            if (b[0]) p ^= a;
            a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
            b = b >> 1;
        end
        return p;
    endfunction

    // column packed with row i at bits [8*i +: 8]
    function automatic logic [31:0] model_col(input logic [31:0] a, input logic inv, input logic byp);
        logic [7:0]  cf[4];
        logic [31:0] r = 32'h0;
        if (byp) return a;
        if (inv) cf = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
        else     cf = '{8'h02, 8'h03, 8'h01, 8'h01};
        for (int i = 0; i < 4; i++)
            for (int k = 0; k < 4; k++)
                r[8*i +: 8] ^= gmul(cf[k], a[8*((i + k) % 4) +: 8]);
        return r;
    endfunction

    function automatic void purge_after(input int t);
        while (exp_cyc_q.size() > 0 && exp_cyc_q[exp_cyc_q.size() - 1] > t) begin
            void'(exp_q.pop_back());
            void'(exp_cyc_q.pop_back());
        end
    endfunction

    // driver: present one cycle of inputs, update the model for the coming edge
    task automatic drive(input logic v, input logic [7:0] b, input logic inv,
                         input logic byp, input logic rs);
        int t;
        logic [31:0] r;
        @(posedge clk);
        #1;
        din_valid = v;
        din       = b;
        inverse   = inv;
        bypass    = byp;
        rst_synch = rs;
        t = cyc;
        if (rs) begin
            purge_after(t);
            part_n  = 0;
            blk_col = 0;
        end else if (v) begin
            part[8*part_n +: 8] = b;
            part_n++;
            if (part_n == 4) begin
                r = model_col(part, inv, byp);
                for (int i = 0; i < 4; i++) begin
                    exp_q.push_back({(blk_col == 3) && (i == 3), r[8*i +: 8]});
                    exp_cyc_q.push_back(t + 1 + i);
                end
                part_n  = 0;
                blk_col = (blk_col + 1) % 4;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic send_col(input logic [31:0] c, input logic inv, input logic byp);
        for (int i = 0; i < 4; i++) drive(1'b1, c[8*i +: 8], inv, byp, 1'b0);
    endtask

    task automatic async_reset(input string name);
        @(posedge clk);
        #1;
        rst_n     = 1'b0;
        din_valid = 1'b0;
        purge_after(cyc - 1);
        part_n  = 0;
        blk_col = 0;
        #1;
        check({name, "_valid"}, dout_valid, 0);
        check({name, "_dout"}, dout, 8'h00);
        check({name, "_last"}, dout_last, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // scoreboard compare: every cycle, mid-cycle
    always @(negedge clk) begin
        if (exp_q.size() > 0 && exp_cyc_q[0] == cyc) begin
            logic [8:0] e;
            e = exp_q.pop_front();
            void'(exp_cyc_q.pop_front());
            check("dout_valid", dout_valid, 1);
            check("dout", dout, e[7:0]);
            check("dout_last", dout_last, e[8]);
        end else begin
            check("idle_valid", dout_valid, 0);
            check("idle_last", dout_last, 0);
        end
    end

    initial begin
        // model pins from hand-computed vectors
        check("pin_fwd1", model_col(32'h455313db, 1'b0, 1'b0), 32'hbca14d8e);
        check("pin_inv1", model_col(32'hbca14d8e, 1'b1, 1'b0), 32'h455313db);
        check("pin_fwd2", model_col(32'h5c220af2, 1'b0, 1'b0), 32'h9d58dc9f);
        check("pin_fwd3", model_col(32'h01010101, 1'b0, 1'b0), 32'h01010101);
        check("pin_fwd4", model_col(32'hc6c6c6c6, 1'b0, 1'b0), 32'hc6c6c6c6);
        check("pin_byp",  model_col(32'h44332211, 1'b1, 1'b1), 32'h44332211);

        #3;
        check("rst_dout", dout, 8'h00);
        check("rst_valid", dout_valid, 0);
        check("rst_last", dout_last, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // 16-byte streaming block, back to back
        send_col(32'h455313db, 1'b0, 1'b0);
        send_col(32'h5c220af2, 1'b0, 1'b0);
        send_col(32'h01010101, 1'b0, 1'b0);
        send_col(32'hc6c6c6c6, 1'b0, 1'b0);
        idle(6);

        send_col(32'h455313db, 1'b0, 1'b0);
        idle(5);
        send_col(32'hbca14d8e, 1'b1, 1'b0);
        idle(2);

        // gaps inside a column, output draining meanwhile
        drive(1'b1, 8'hf2, 1'b0, 1'b0, 1'b0);
        idle(3);
        drive(1'b1, 8'h0a, 1'b0, 1'b0, 1'b0);
        idle(1);
        drive(1'b1, 8'h22, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 8'h5c, 1'b0, 1'b0, 1'b0);
        idle(6);

        send_col(32'h44332211, 1'b1, 1'b1);
        idle(5);

        // mode only counts at the row3 edge
        drive(1'b1, 8'hdb, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 8'h13, 1'b0, 1'b1, 1'b0);
        drive(1'b1, 8'h53, 1'b1, 1'b1, 1'b0);
        drive(1'b1, 8'h45, 1'b0, 1'b0, 1'b0);
        idle(5);

        // async reset during drain with a half column pending
        send_col(32'h455313db, 1'b0, 1'b0);
        drive(1'b1, 8'haa, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 8'hbb, 1'b0, 1'b0, 1'b0);
        async_reset("arst");
        send_col(32'h455313db, 1'b0, 1'b0);
        idle(5);

        // same with synchronous clear
        send_col(32'h455313db, 1'b0, 1'b0);
        drive(1'b1, 8'haa, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 8'hbb, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 8'hcc, 1'b0, 1'b0, 1'b1);
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        check("srst_valid", dout_valid, 0);
        send_col(32'h455313db, 1'b0, 1'b0);
        idle(6);

        check("queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
